// File: rtl/prewish_pattern_initiator.sv
// Initiator end of the prewish link: debounces the board pushbutton and, on
// each press, strobes the next LED mask pattern into the blinky student.
// Pattern 0 is strobed automatically once reset is released.
module prewish_pattern_initiator #(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned NUM_PATTERNS  = 8,
  parameter logic [63:0] PATTERNS      = 64'h00_FE_E0_80_AA_CC_F0_A0,
  parameter int unsigned STB_CYCLES    = 4,
  parameter bit          USE_ACK       = 1'b0,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_button,
  input  logic       ACK_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [2:0] o_pattern_idx,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STROBE = 2'd2
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] DB_FULL  = '1;
  localparam logic [2:0]               LAST_IDX = 3'(NUM_PATTERNS - 1);
  localparam logic [7:0]               STB_LEN  = USE_ACK ? 8'(ACK_TIMEOUT) : 8'(STB_CYCLES);

  // Table entry i occupies byte i of the packed pattern word.
  function automatic logic [7:0] pattern_at(input logic [2:0] sel);
    return PATTERNS[{sel, 3'b000} +: 8];
  endfunction

  logic [1:0]               sync_q, sync_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
  logic                     db_level_q, db_level_d;
  logic                     press_q, press_d;

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       stb_q, stb_d;
  logic [7:0] dat_q, dat_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] stb_cnt_q, stb_cnt_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;

  logic [2:0]               next_idx;
  logic [DEBOUNCE_BITS-1:0] db_cnt_inc;
  logic                     start_strobe;
  logic                     last_cycle;
  logic                     ack_seen;
  logic                     strobe_end;
  logic                     ack_timeout;

  assign next_idx     = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
  assign db_cnt_inc   = db_cnt_q + 1'b1;
  assign start_strobe = (state_q == ST_IDLE) && (press_q || pend_q);
  assign last_cycle   = (stb_cnt_q == 8'd1);
  assign ack_seen     = USE_ACK && ACK_I;
  assign strobe_end   = (state_q == ST_STROBE) && (ack_seen || last_cycle);
  assign ack_timeout  = (state_q == ST_STROBE) && USE_ACK && !ACK_I && last_cycle;

  // Synchronizer, debounce run counter, accepted level and rising-edge press event.
  always_comb begin
    sync_d     = {sync_q[0], i_button};
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync_q[1] == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_inc == DB_FULL) begin
      db_level_d = sync_q[1];
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_inc;
    end
    press_d = db_level_d & ~db_level_q;
  end

  // Input conditioning registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sync_q     <= 2'b00;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
    end
  end

  // State register; busy is registered alongside so it tracks the state exactly.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_INIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   state_d = ST_STROBE;
      ST_IDLE:   if (start_strobe) state_d = ST_STROBE;
      ST_STROBE: if (strobe_end) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Output and datapath next values: pattern select, strobe timing, pending press, error.
  always_comb begin
    stb_d     = stb_q;
    dat_d     = dat_q;
    idx_d     = idx_q;
    stb_cnt_d = stb_cnt_q;
    pend_d    = pend_q;
    err_d     = err_q;
    if (press_q && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end
    unique case (state_q)
      ST_INIT: begin
        stb_d     = 1'b1;
        dat_d     = pattern_at(3'd0);
        idx_d     = 3'd0;
        stb_cnt_d = STB_LEN;
      end
      ST_IDLE: begin
        if (start_strobe) begin
          stb_d     = 1'b1;
          dat_d     = pattern_at(next_idx);
          idx_d     = next_idx;
          stb_cnt_d = STB_LEN;
          pend_d    = 1'b0;
        end
      end
      ST_STROBE: begin
        if (strobe_end) begin
          stb_d = 1'b0;
        end else begin
          stb_cnt_d = stb_cnt_q - 8'd1;
        end
        if (ack_timeout) begin
          err_d = 1'b1;
        end
      end
      default: begin
        stb_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; the async reset drops the strobe without waiting for a clock.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      stb_q     <= 1'b0;
      dat_q     <= 8'h00;
      idx_q     <= 3'd0;
      stb_cnt_q <= 8'd0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stb_q     <= stb_d;
      dat_q     <= dat_d;
      idx_q     <= idx_d;
      stb_cnt_q <= stb_cnt_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign STB_O         = stb_q;
  assign DAT_O         = dat_q;
  assign o_pattern_idx = idx_q;
  assign o_busy        = busy_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_prewish_pattern_initiator.sv
// Bench for prewish_pattern_initiator: four differently configured instances
// share clock and reset; a behavioural model predicts every output each cycle
// and directed scenarios pin key values by hand.
module tb_prewish_pattern_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      btn;
  logic [3:0]      ack;
  logic [3:0]      stb;
  logic [3:0]      busy;
  logic [3:0]      err;
  logic [3:0][7:0] dat;
  logic [3:0][2:0] idx;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Instance 0: defaults with a short debounce; 1: pending collapse; 2: ACK mode; 3: single pattern
  prewish_pattern_initiator #(.DEBOUNCE_BITS(3)) u_dut0 (
    .CLK_I(clk), .RST_I(rst_n), .i_button(btn[0]), .ACK_I(ack[0]), .STB_O(stb[0]),
    .DAT_O(dat[0]), .o_pattern_idx(idx[0]), .o_busy(busy[0]), .o_err(err[0]));
  prewish_pattern_initiator #(.DEBOUNCE_BITS(2), .NUM_PATTERNS(3), .STB_CYCLES(20)) u_dut1 (
    .CLK_I(clk), .RST_I(rst_n), .i_button(btn[1]), .ACK_I(ack[1]), .STB_O(stb[1]),
    .DAT_O(dat[1]), .o_pattern_idx(idx[1]), .o_busy(busy[1]), .o_err(err[1]));
  prewish_pattern_initiator #(.DEBOUNCE_BITS(3), .USE_ACK(1'b1), .ACK_TIMEOUT(5)) u_dut2 (
    .CLK_I(clk), .RST_I(rst_n), .i_button(btn[2]), .ACK_I(ack[2]), .STB_O(stb[2]),
    .DAT_O(dat[2]), .o_pattern_idx(idx[2]), .o_busy(busy[2]), .o_err(err[2]));
  prewish_pattern_initiator #(.DEBOUNCE_BITS(3), .NUM_PATTERNS(1), .STB_CYCLES(2)) u_dut3 (
    .CLK_I(clk), .RST_I(rst_n), .i_button(btn[3]), .ACK_I(ack[3]), .STB_O(stb[3]),
    .DAT_O(dat[3]), .o_pattern_idx(idx[3]), .o_busy(busy[3]), .o_err(err[3]));

  int cfgDb  [4] = '{3, 2, 3, 3};
  int cfgNp  [4] = '{8, 3, 8, 1};
  int cfgStb [4] = '{4, 20, 4, 2};
  int cfgAck [4] = '{0, 0, 1, 0};
  int cfgTo  [4] = '{16, 16, 5, 16};
  logic [7:0] patTable [8] = '{8'hA0, 8'hF0, 8'hCC, 8'hAA, 8'h80, 8'hE0, 8'hFE, 8'h00};

  // Model state: two-stage sample history, run of samples disagreeing with the
  // accepted level, press event, pending flag, strobe high-cycle count.
  bit         mS1 [4];
  bit         mS2 [4];
  int         mRun [4];
  bit         mLevel [4];
  bit         mPress [4];
  bit         mPend [4];
  bit         mInit [4];
  bit         mStb [4];
  bit         mErr [4];
  int         mHi [4];
  int         mIdx [4];
  logic [7:0] mDat [4];
  bit         mEv;

  // Behavioural model, advanced on each clock and cleared by the async reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        mS1[i] = 0; mS2[i] = 0; mRun[i] = 0; mLevel[i] = 0; mPress[i] = 0;
        mPend[i] = 0; mInit[i] = 1; mStb[i] = 0; mErr[i] = 0; mHi[i] = 0;
        mIdx[i] = 0; mDat[i] = 8'h00;
      end else begin
        mEv = mPress[i];
        if (mInit[i]) begin
          mInit[i] = 0; mIdx[i] = 0; mDat[i] = patTable[0]; mStb[i] = 1; mHi[i] = 1;
          if (mEv) mPend[i] = 1;
        end else if (mStb[i]) begin
          if (mEv) mPend[i] = 1;
          if (cfgAck[i] != 0) begin
            if (ack[i]) mStb[i] = 0;
            else if (mHi[i] == cfgTo[i]) begin mStb[i] = 0; mErr[i] = 1; end
            else mHi[i]++;
          end else if (mHi[i] == cfgStb[i]) mStb[i] = 0;
          else mHi[i]++;
        end else if (mEv || mPend[i]) begin
          mIdx[i] = (mIdx[i] + 1) % cfgNp[i];
          mDat[i] = patTable[mIdx[i]];
          mStb[i] = 1; mHi[i] = 1; mPend[i] = 0;
        end
        mPress[i] = 0;
        if (mS2[i] == mLevel[i]) mRun[i] = 0;
        else begin
          mRun[i]++;
          if (mRun[i] == (1 << cfgDb[i]) - 1) begin
            mLevel[i] = mS2[i]; mRun[i] = 0; mPress[i] = mLevel[i];
          end
        end
        mS2[i] = mS1[i];
        mS1[i] = btn[i];
      end
    end
  end

  // Compare every instance against the model on each falling edge
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({stb[i], dat[i], idx[i], busy[i], err[i]} !== {mStb[i], mDat[i], 3'(mIdx[i]), mStb[i], mErr[i]}) begin
          errors++;
          $display("[TB] FAIL model_dut%0d t=%0t got stb=%b dat=%h idx=%0d busy=%b err=%b want stb=%b dat=%h idx=%0d busy=%b err=%b",
                   i, $time, stb[i], dat[i], idx[i], busy[i], err[i], mStb[i], mDat[i], mIdx[i], mStb[i], mErr[i]);
        end
      end
    end
  end

  // Strobe statistics: number of strobes, last high length, last low gap before a strobe
  int strobes [4];
  int lastHi [4];
  int lastGap [4];
  int hiRun [4];
  int loRun [4];
  bit prevStb [4];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (stb[i] === 1'b1) begin
        if (!prevStb[i]) begin strobes[i]++; lastGap[i] = loRun[i]; hiRun[i] = 0; end
        hiRun[i]++;
        prevStb[i] = 1;
      end else begin
        if (prevStb[i]) begin lastHi[i] = hiRun[i]; loRun[i] = 0; end
        loRun[i]++;
        prevStb[i] = 0;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [3:0] a, input int n);
    btn = b;
    ack = a;
    tick(n);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got %0h want %0h", name, $time, actual, expected);
    end
  endtask

  task automatic waitStrobe(input int which);
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (stb[which] === 1'b1) break;
    end
    checkOutput("strobe_seen", 32'(stb[which]), 32'd1);
  endtask

  logic [7:0] seqDat [8] = '{8'hF0, 8'hCC, 8'hAA, 8'h80, 8'hE0, 8'hFE, 8'h00, 8'hA0};
  int         seqIdx [8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    btn   = 4'b0000;
    ack   = 4'b0100;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(1);
    checkEn = 1'b1;
    tick(1);
    checkOutput("reset_stb", 32'(stb[0]), 32'd0);
    checkOutput("reset_dat", 32'(dat[0]), 32'd0);
    checkOutput("reset_busy", 32'(busy[0]), 32'd0);
    checkOutput("reset_err", 32'(err[0]), 32'd0);

    // Reset release: four strobe cycles of entry 0
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      checkOutput("init_stb", 32'(stb[0]), 32'd1);
      checkOutput("init_dat", 32'(dat[0]), 32'hA0);
      checkOutput("init_busy", 32'(busy[0]), 32'd1);
    end
    tick(1);
    checkOutput("init_end_stb", 32'(stb[0]), 32'd0);
    checkOutput("init_end_busy", 32'(busy[0]), 32'd0);
    checkOutput("init_end_err", 32'(err[0]), 32'd0);
    checkOutput("ack_init_err", 32'(err[2]), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4);

    // Eight clean presses walk the table and wrap; single-pattern instance stays at 0
    for (int p = 0; p < 8; p++) begin
      applyStimulus(4'b1001, 4'b0000, 12);
      applyStimulus(4'b0000, 4'b0000, 12);
      checkOutput("seq_idx", 32'(idx[0]), 32'(seqIdx[p]));
      checkOutput("seq_dat", 32'(dat[0]), 32'(seqDat[p]));
      checkOutput("np1_idx", 32'(idx[3]), 32'd0);
      checkOutput("np1_dat", 32'(dat[3]), 32'hA0);
    end
    checkOutput("seq_strobes", 32'(strobes[0]), 32'd9);
    checkOutput("np1_strobes", 32'(strobes[3]), 32'd9);
    checkOutput("seq_hi_len", 32'(lastHi[0]), 32'd4);

    // Debounce: six cycles held is rejected, twelve is accepted once
    applyStimulus(4'b0001, 4'b0000, 6);
    applyStimulus(4'b0000, 4'b0000, 10);
    checkOutput("short_press_strobes", 32'(strobes[0]), 32'd9);
    applyStimulus(4'b0001, 4'b0000, 12);
    applyStimulus(4'b0000, 4'b0000, 12);
    checkOutput("long_press_strobes", 32'(strobes[0]), 32'd10);
    checkOutput("long_press_idx", 32'(idx[0]), 32'd1);
    checkOutput("long_press_dat", 32'(dat[0]), 32'hF0);

    // Three quick presses: the last two land inside the first strobe and collapse
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'b0010, 4'b0000, 3);
      applyStimulus(4'b0000, 4'b0000, 3);
    end
    tick(60);
    checkOutput("pend_strobes", 32'(strobes[1]), 32'd3);
    checkOutput("pend_gap", 32'(lastGap[1]), 32'd1);
    checkOutput("pend_hi_len", 32'(lastHi[1]), 32'd20);
    checkOutput("pend_idx", 32'(idx[1]), 32'd2);
    checkOutput("pend_dat", 32'(dat[1]), 32'hCC);

    // ACK mode: ACK on third strobe cycle, then a timeout, then an acked strobe
    btn = 4'b0100;
    waitStrobe(2);
    tick(2);
    ack = 4'b0100;
    tick(1);
    ack = 4'b0000;
    checkOutput("ack_stb", 32'(stb[2]), 32'd0);
    checkOutput("ack_err", 32'(err[2]), 32'd0);
    checkOutput("ack_hi_len", 32'(lastHi[2]), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 12);
    btn = 4'b0100;
    waitStrobe(2);
    tick(4);
    checkOutput("to_still_high", 32'(stb[2]), 32'd1);
    tick(1);
    checkOutput("to_stb", 32'(stb[2]), 32'd0);
    checkOutput("to_err", 32'(err[2]), 32'd1);
    checkOutput("to_hi_len", 32'(lastHi[2]), 32'd5);
    applyStimulus(4'b0000, 4'b0000, 12);
    applyStimulus(4'b0100, 4'b0100, 12);
    applyStimulus(4'b0000, 4'b0000, 12);
    checkOutput("acked_hi_len", 32'(lastHi[2]), 32'd1);
    checkOutput("err_sticky", 32'(err[2]), 32'd1);
    checkOutput("ack_strobes", 32'(strobes[2]), 32'd4);
    checkOutput("ack_dat", 32'(dat[2]), 32'hAA);

    // Reset on the second strobe cycle clears outputs without a clock edge
    btn = 4'b0001;
    waitStrobe(0);
    checkOutput("pre_reset_dat", 32'(dat[0]), 32'hCC);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_stb", 32'(stb[0]), 32'd0);
    checkOutput("async_rst_dat", 32'(dat[0]), 32'd0);
    checkOutput("async_rst_idx", 32'(idx[0]), 32'd0);
    btn = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("reinit_stb", 32'(stb[0]), 32'd1);
    checkOutput("reinit_dat", 32'(dat[0]), 32'hA0);
    checkOutput("reinit_idx", 32'(idx[0]), 32'd0);
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
